// File: rtl/test_stream_checker.sv
// AXI4-Stream test sink: per-lane incrementing-pattern check, packet-length check,
// first-error capture and saturating statistics for multi-packet runs.
module test_stream_checker #(
  parameter int unsigned LANE_WIDTH  = 16,
  parameter int unsigned LANES       = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            stop,
  input  logic [COUNT_WIDTH-1:0]          num_packets,
  input  logic [COUNT_WIDTH-1:0]          expected_length,
  output logic                            idle,
  output logic                            done,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic                            s_tlast,
  input  logic [LANE_WIDTH*LANES-1:0]     s_tdata,
  output logic [COUNT_WIDTH-1:0]          beat_count,
  output logic [COUNT_WIDTH-1:0]          miss_count,
  output logic [COUNT_WIDTH-1:0]          error_count,
  output logic [COUNT_WIDTH-1:0]          length_error_count,
  output logic [COUNT_WIDTH-1:0]          packet_count,
  output logic                            first_error_valid,
  output logic [COUNT_WIDTH-1:0]          first_error_beat,
  output logic [LANE_WIDTH*LANES-1:0]     first_error_data
);

  localparam int unsigned DATA_WIDTH = LANE_WIDTH * LANES;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic                   done_next;
  logic [COUNT_WIDTH-1:0] num_packets_q;
  logic [COUNT_WIDTH-1:0] expected_length_q;
  logic [LANE_WIDTH-1:0]  base;
  logic [COUNT_WIDTH-1:0] pkt_index;

  logic                   active;
  logic                   accept;
  logic                   miss;
  logic                   tlast_accept;
  logic                   lane_error;
  logic                   last_packet;
  logic                   length_bad;
  logic [COUNT_WIDTH-1:0] packet_count_inc;
  logic [COUNT_WIDTH-1:0] pkt_index_inc;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign active           = (state != ST_IDLE);
  assign accept           = active & s_tvalid;
  assign miss             = active & ~s_tvalid;
  assign tlast_accept     = accept & s_tlast;
  assign packet_count_inc = sat_inc(packet_count);
  assign pkt_index_inc    = sat_inc(pkt_index);
  assign last_packet      = tlast_accept && (num_packets_q != '0) &&
                            (packet_count_inc == num_packets_q);
  assign length_bad       = (expected_length_q != '0) && (pkt_index_inc != expected_length_q);

  // Lane i of the current beat must equal base + i (mod 2^LANE_WIDTH).
  always_comb begin
    lane_error = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s_tdata[i*LANE_WIDTH +: LANE_WIDTH] != LANE_WIDTH'(base + LANE_WIDTH'(i)))
        lane_error = 1'b1;
    end
  end

  // Next-state logic; start overrides stop and tlast.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (start) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (last_packet || (stop && (tlast_accept || pkt_index == '0))) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (stop) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tlast_accept) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idle     <= 1'b1;
      s_tready <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idle     <= (state_next == ST_IDLE);
      s_tready <= (state_next != ST_IDLE);
      done     <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_packets_q     <= '0;
      expected_length_q <= '0;
    end else if (start) begin
      num_packets_q     <= num_packets;
      expected_length_q <= expected_length;
    end
  end

  // Statistics, pattern tracking and first-error capture.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      beat_count         <= '0;
      miss_count         <= '0;
      error_count        <= '0;
      length_error_count <= '0;
      packet_count       <= '0;
      first_error_valid  <= 1'b0;
      first_error_beat   <= '0;
      first_error_data   <= '0;
      base               <= '0;
      pkt_index          <= '0;
    end else begin
      if (miss) miss_count <= sat_inc(miss_count);
      if (accept) begin
        beat_count <= sat_inc(beat_count);
        if (lane_error) begin
          error_count <= sat_inc(error_count);
          if (!first_error_valid) begin
            first_error_valid <= 1'b1;
            first_error_beat  <= beat_count;
            first_error_data  <= DATA_WIDTH'(s_tdata);
          end
        end
        if (s_tlast) begin
          base         <= '0;
          pkt_index    <= '0;
          packet_count <= packet_count_inc;
          if (length_bad) length_error_count <= sat_inc(length_error_count);
        end else begin
          base      <= LANE_WIDTH'(s_tdata[LANE_WIDTH-1:0] + LANE_WIDTH'(LANES));
          pkt_index <= pkt_index_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_stream_checker.sv
// Directed, table-driven bench for test_stream_checker (LANES=2, LANE_WIDTH=16),
// with a second COUNT_WIDTH=4 instance sharing the stimulus for saturation.
module tb_test_stream_checker;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [31:0] num_packets, expected_length;
  logic        s_tvalid, s_tlast;
  logic [31:0] s_tdata;

  logic        idle, done, s_tready, first_error_valid;
  logic [31:0] beat_count, miss_count, error_count, length_error_count, packet_count;
  logic [31:0] first_error_beat, first_error_data;

  logic        idle4, done4, s_tready4, first_error_valid4;
  logic [3:0]  beat_count4, miss_count4, error_count4, length_error_count4, packet_count4;
  logic [3:0]  first_error_beat4;
  logic [31:0] first_error_data4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  test_stream_checker #(.LANE_WIDTH(16), .LANES(2), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .num_packets(num_packets), .expected_length(expected_length),
    .idle(idle), .done(done), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata),
    .beat_count(beat_count), .miss_count(miss_count), .error_count(error_count),
    .length_error_count(length_error_count), .packet_count(packet_count),
    .first_error_valid(first_error_valid), .first_error_beat(first_error_beat),
    .first_error_data(first_error_data)
  );

  test_stream_checker #(.LANE_WIDTH(16), .LANES(2), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .num_packets(4'(num_packets)), .expected_length(4'(expected_length)),
    .idle(idle4), .done(done4), .s_tvalid(s_tvalid), .s_tready(s_tready4),
    .s_tlast(s_tlast), .s_tdata(s_tdata),
    .beat_count(beat_count4), .miss_count(miss_count4), .error_count(error_count4),
    .length_error_count(length_error_count4), .packet_count(packet_count4),
    .first_error_valid(first_error_valid4), .first_error_beat(first_error_beat4),
    .first_error_data(first_error_data4)
  );

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] d;
    int          beat, miss, err, pkt, len;
    logic        idle, done;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic v, input logic l, input logic [31:0] d,
                              input int beat, input int miss, input int pkt,
                              input int len, input logic idl, input logic dn);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.beat = beat; r.miss = miss; r.err = 0;
    r.pkt = pkt; r.len = len; r.idle = idl; r.done = dn;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] l1, input logic [15:0] l0, input logic last);
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tdata  = {l1, l0};
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] np, input logic [31:0] el);
    num_packets     = np;
    expected_length = el;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " idle"}, 32'(idle), 32'd1);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " s_tready"}, 32'(s_tready), 32'd0);
    check({tag, " beat_count"}, beat_count, 32'd0);
    check({tag, " miss_count"}, miss_count, 32'd0);
    check({tag, " error_count"}, error_count, 32'd0);
    check({tag, " packet_count"}, packet_count, 32'd0);
    check({tag, " first_error_valid"}, 32'(first_error_valid), 32'd0);
    check({tag, " first_error_beat"}, first_error_beat, 32'd0);
    check({tag, " first_error_data"}, first_error_data, 32'd0);
  endtask

  initial begin
    // Three packets (4, 3, 4 beats) with an idle cycle between beats.
    vecs[0]  = mk(1, 0, 32'h0001_0000,  1,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,          1,  1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h0003_0002,  2,  1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,          2,  2, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 32'h0005_0004,  3,  2, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,          3,  3, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 32'h0007_0006,  4,  3, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 32'h0,          4,  4, 1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 32'h0001_0000,  5,  4, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 32'h0,          5,  5, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 32'h0003_0002,  6,  5, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 32'h0,          6,  6, 1, 0, 0, 0);
    vecs[12] = mk(1, 1, 32'h0005_0004,  7,  6, 2, 1, 0, 0);
    vecs[13] = mk(0, 0, 32'h0,          7,  7, 2, 1, 0, 0);
    vecs[14] = mk(1, 0, 32'h0001_0000,  8,  7, 2, 1, 0, 0);
    vecs[15] = mk(0, 0, 32'h0,          8,  8, 2, 1, 0, 0);
    vecs[16] = mk(1, 0, 32'h0003_0002,  9,  8, 2, 1, 0, 0);
    vecs[17] = mk(0, 0, 32'h0,          9,  9, 2, 1, 0, 0);
    vecs[18] = mk(1, 0, 32'h0005_0004, 10,  9, 2, 1, 0, 0);
    vecs[19] = mk(0, 0, 32'h0,         10, 10, 2, 1, 0, 0);
    vecs[20] = mk(1, 1, 32'h0007_0006, 11, 10, 3, 1, 1, 1);
    vecs[21] = mk(0, 0, 32'h0,         11, 10, 3, 1, 1, 0);

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    num_packets = '0; expected_length = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    tick(); tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // Single clean packet.
    do_start(32'd1, 32'd4);
    check("start beat_count", beat_count, 32'd0);
    check("start s_tready", 32'(s_tready), 32'd1);
    check("start idle", 32'(idle), 32'd0);
    beat(16'd1, 16'd0, 1'b0);
    beat(16'd3, 16'd2, 1'b0);
    beat(16'd5, 16'd4, 1'b0);
    check("pkt1 no early done", 32'(done), 32'd0);
    beat(16'd7, 16'd6, 1'b1);
    check("pkt1 beat_count", beat_count, 32'd4);
    check("pkt1 miss_count", miss_count, 32'd0);
    check("pkt1 error_count", error_count, 32'd0);
    check("pkt1 length_error_count", length_error_count, 32'd0);
    check("pkt1 packet_count", packet_count, 32'd1);
    check("pkt1 done", 32'(done), 32'd1);
    check("pkt1 idle", 32'(idle), 32'd1);
    tick();
    check("pkt1 done one cycle", 32'(done), 32'd0);

    // Pattern error on third beat, resync on fourth.
    do_start(32'd1, 32'd4);
    beat(16'd1, 16'd0, 1'b0);
    beat(16'd3, 16'd2, 1'b0);
    beat(16'd9, 16'd8, 1'b0);
    beat(16'd11, 16'd10, 1'b1);
    check("err error_count", error_count, 32'd1);
    check("err first_error_valid", 32'(first_error_valid), 32'd1);
    check("err first_error_beat", first_error_beat, 32'd2);
    check("err first_error_data", first_error_data, 32'h0009_0008);
    check("err packet_count", packet_count, 32'd1);
    check("err done", 32'(done), 32'd1);
    tick();

    // Table-driven multi-packet run.
    do_start(32'd3, 32'd4);
    for (int i = 0; i < 22; i++) begin
      s_tvalid = vecs[i].v;
      s_tlast  = vecs[i].l;
      s_tdata  = vecs[i].d;
      tick();
      check($sformatf("vec%0d beat_count", i), beat_count, 32'(vecs[i].beat));
      check($sformatf("vec%0d miss_count", i), miss_count, 32'(vecs[i].miss));
      check($sformatf("vec%0d error_count", i), error_count, 32'(vecs[i].err));
      check($sformatf("vec%0d packet_count", i), packet_count, 32'(vecs[i].pkt));
      check($sformatf("vec%0d length_error_count", i), length_error_count, 32'(vecs[i].len));
      check($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].idle));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;

    // Stop mid-packet in continuous mode drains to the tlast.
    do_start(32'd0, 32'd4);
    beat(16'd1, 16'd0, 1'b0);
    beat(16'd3, 16'd2, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain s_tready", 32'(s_tready), 32'd1);
    check("drain idle", 32'(idle), 32'd0);
    check("drain done", 32'(done), 32'd0);
    beat(16'd5, 16'd4, 1'b0);
    check("drain still busy", 32'(idle), 32'd0);
    beat(16'd7, 16'd6, 1'b1);
    check("drain done pulse", 32'(done), 32'd1);
    check("drain end idle", 32'(idle), 32'd1);
    check("drain packet_count", packet_count, 32'd1);
    check("drain miss_count", miss_count, 32'd1);
    check("drain error_count", error_count, 32'd0);
    tick();
    check("drain done one cycle", 32'(done), 32'd0);

    // Saturation (4-bit instance) and lane wrap across 0xFFFF.
    do_start(32'd0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      logic [15:0] l0;
      l0 = 16'(16'hFFFC + 16'(2 * k));
      beat(16'(l0 + 16'd1), l0, 1'b0);
      if (k == 0) check("wrap seed error", error_count, 32'd1);
      if (k == 2) check("wrap no error", error_count, 32'd1);
    end
    check("sat beat_count 32b", beat_count, 32'd20);
    check("sat beat_count 4b", 32'(beat_count4), 32'd15);
    check("sat error_count 4b", 32'(error_count4), 32'd1);
    check("wrap first_error_beat", first_error_beat, 32'd0);
    check("wrap first_error_data", first_error_data, 32'hFFFD_FFFC);

    // Reset mid-packet (with a coincident start) returns to reset values.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pre-reset drain", 32'(idle), 32'd0);
    beat(16'd1, 16'd0, 1'b0);
    reset = 1'b1; start = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h0003_0002;
    tick();
    reset = 1'b0; start = 1'b0; s_tvalid = 1'b0;
    check_reset_values("midreset");
    tick();
    check("midreset no done", 32'(done), 32'd0);
    check("midreset stays idle", 32'(idle), 32'd1);

    // Start coinciding with an accepted tlast.
    do_start(32'd1, 32'd4);
    beat(16'd1, 16'd0, 1'b0);
    start = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 32'h0003_0002;
    tick();
    start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    check("start+tlast beat_count", beat_count, 32'd0);
    check("start+tlast packet_count", packet_count, 32'd0);
    check("start+tlast idle", 32'(idle), 32'd0);
    check("start+tlast done", 32'(done), 32'd0);
    check("start+tlast s_tready", 32'(s_tready), 32'd1);
    tick();
    check("start+tlast running miss", miss_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_stream_checker.md
# test_stream_checker

Parametrised AXI4-Stream sink for bandwidth and integrity testing of stream datapaths. It generalises the single-packet test sink:
- multi-lane packed samples with per-lane incrementing-pattern checking;
- multi-packet runs with a packet-length check;
- first-error capture, graceful stop and saturating statistics counters.

It sits at the end of a DMA/ADC test pipeline and is controlled and read back through the test register bank.

## Interface
- LANE_WIDTH, 16: bits per sample lane.
- LANES, 2: sample lanes per beat; tdata width = LANE_WIDTH*LANES, lane 0 in LSBs.
- COUNT_WIDTH, 32: width of all statistics counters and length/packet inputs.
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; clears statistics and begins a run.
- stop  in  1  pulse; ends a continuous run at the next packet boundary.
- num_packets  in  COUNT_WIDTH  packets per run, sampled on start; 0 = continuous until stop.
- expected_length  in  COUNT_WIDTH  beats per packet, sampled on start; 0 = length check disabled.
- idle  out  1  high when not running.
- done  out  1  one-cycle pulse when a run ends.
- s_tvalid  in  1; s_tready  out  1; s_tlast  in  1.
- s_tdata  in  LANE_WIDTH*LANES.
- beat_count, miss_count, error_count, length_error_count, packet_count  out  COUNT_WIDTH each.
- first_error_valid  out  1  sticky flag; a pattern error has been captured.
- first_error_beat  out  COUNT_WIDTH  beat index (0-based since start) of the first pattern error.
- first_error_data  out  LANE_WIDTH*LANES  tdata of that beat.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: s_tready=0, idle=1.
- RUN, DRAIN: s_tready=1, idle=0.
- IDLE -> RUN on start.
- start in any state:
  - restarts the run and re-samples num_packets and expected_length;
  - clears all counters, the first_error_* outputs and the pattern state;
  - start wins over stop and over tlast in the same cycle.
- RUN -> IDLE with done: on an accepted tlast beat that makes packet_count equal num_packets (num_packets != 0).
- RUN -> IDLE with done: on stop when the in-packet beat index is 0.
- RUN -> DRAIN: on stop mid-packet.
- DRAIN -> IDLE with done: on the next accepted tlast beat. An accepted tlast in the same cycle as stop goes directly to IDLE.
- Accepted beat = RUN/DRAIN & s_tvalid. Miss = RUN/DRAIN & ~s_tvalid.
- beat_count +1 per accepted beat; miss_count +1 per miss.
- Pattern expectation: lane i expects base+i, mod 2^LANE_WIDTH.
  - base starts at 0.
  - Each accepted beat sets base = lane0 received + LANES (resynchronises after an error).
  - An accepted tlast beat sets base = 0.
- error_count +1 per accepted beat with any lane mismatch; counted once per beat regardless of how many lanes mismatch.
- First mismatching beat since start: latch first_error_beat = beat_count before increment, first_error_data = s_tdata, set first_error_valid. Later errors do not overwrite.
- In-packet index counts accepted beats. On accepted tlast:
  - length_error_count +1 if expected_length != 0 and index+1 != expected_length;
  - packet_count +1;
  - index resets to 0.
- All counters saturate at 2^COUNT_WIDTH-1; no wrap.

## Timing
- Reset values:
  - state IDLE, idle=1, done=0, s_tready=0;
  - all counters 0, first_error_valid=0, first_error_beat=0, first_error_data=0;
  - base 0, in-packet index 0.
- Reset mid-run: returns to IDLE next edge, no done pulse. Reset overrides start.
- Start sampled at edge n: counters read 0 and s_tready=1 after edge n. The first beat can be accepted in cycle n+1.
- Counters and first_error_* update at the edge that accepts the beat; visible the following cycle.
- done and idle assert together after the edge accepting the final tlast (or the stop edge). done lasts exactly one cycle.
- s_tready is a pure function of registered state; no combinational path from s_tvalid.

## Test plan
- LANES=2, LANE_WIDTH=16:
  - start, num_packets=1, expected_length=4; send beats {1,0},{3,2},{5,4},{7,6}, tlast on the 4th, tvalid continuous.
  - Required: beat_count=4, miss_count=0, error_count=0, length_error_count=0, packet_count=1, done one pulse, idle=1.
- Same setup, third beat {9,8}:
  - Required: error_count=1 (beat 4 resynced, no error), first_error_valid=1, first_error_beat=2, first_error_data=0x00090008.
- num_packets=3, expected_length=4, packets of 4, 3, 4 beats with one idle cycle between beats:
  - Required: packet_count=3, length_error_count=1.
  - miss_count equals the number of idle cycles in RUN.
  - Pattern restarts at {1,0} after each tlast with no errors.
- num_packets=0; stop pulsed after beat 2 of a 4-beat packet:
  - Required: DRAIN, s_tready stays 1, done after the tlast beat, packet_count=1.
- Saturation and wrap:
  - COUNT_WIDTH=4, 20 accepted beats: beat_count=15.
  - Lanes {0xFFFF,0xFFFE} followed by {0x0001,0x0000}: no pattern error.
- Asynchronous-to-protocol events:
  - reset mid-packet: all outputs return to reset values, no done pulse.
  - start coinciding with tlast: counters 0, state RUN.
